// File: rtl/bist_pkg.sv
// Shared types and constants for the JTAG BIST sequencer: state encoding,
// LFSR/MISR feedback taps, configuration field indices and the default seed.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } bist_state_e;

  // Taps 16,14,13,11 of a maximal-length 16-bit Fibonacci register
  localparam logic [15:0] TAP_MASK     = 16'hB400;
  localparam int          CNT_MSB      = 11;
  localparam int          CNT_LSB      = 0;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [15:0] fixSeed(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit shift register with parallel load, shift enable and XOR-in data port;
// serves as the stimulus LFSR (data tied to 0) and as the response MISR.
module bist_lfsr16
  import bist_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [15:0] loadVal_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] q_o
);

  logic [15:0] shift_q;
  logic [15:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = loadVal_i;
    end else if (en_i) begin
      shift_d = {shift_q[14:0], ^(shift_q & TAP_MASK)} ^ data_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q <= RESET_VAL;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q;

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer between the TAP BIST register and the CUT: LFSR stimulus, MISR
// compaction, done/pass status. Golden comparator built only with BIST_GOLDEN_CMP_EN.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int          CUT_W      = 16,
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             BIST_FSM_RES_i,
  input  logic             BIST_clk_en_i,
  input  logic             BIST_Mode_Sel_i,
  input  logic [15:0]      From_BIST_reg_i,
  input  logic [CUT_W-1:0] CUT_resp_i,
  output logic [CUT_W-1:0] CUT_stim_o,
  output logic [15:0]      To_BIST_reg_o,
  output logic             BIST_busy_o,
  output logic             BIST_done_o,
  output logic             BIST_pass_o
);

  localparam logic [15:0] SeedEff = fixSeed(SEED);

  bist_state_e state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        restart;
  logic        loadEn;
  logic        advEn;
  logic [11:0] patCount;
  logic [15:0] lfsr;
  logic [15:0] misr;
  logic [15:0] respExt;

  assign patCount = From_BIST_reg_i[CNT_MSB:CNT_LSB];
  assign restart  = BIST_FSM_RES_i & BIST_Mode_Sel_i;
  // A restart always pre-empts loading or advancing in the same cycle
  assign loadEn   = (state_q == ST_LOAD) & BIST_Mode_Sel_i & ~restart;
  assign advEn    = (state_q == ST_RUN) & BIST_Mode_Sel_i & ~restart & BIST_clk_en_i;

  always_comb begin
    respExt = '0;
    respExt[CUT_W-1:0] = CUT_resp_i;
  end

  bist_lfsr16 #(.RESET_VAL(SeedEff)) u_lfsr (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load_i   (loadEn),
    .loadVal_i(SeedEff),
    .en_i     (advEn),
    .data_i   (16'h0000),
    .q_o      (lfsr)
  );

  bist_lfsr16 #(.RESET_VAL(16'h0000)) u_misr (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load_i   (loadEn),
    .loadVal_i(16'h0000),
    .en_i     (advEn),
    .data_i   (respExt),
    .q_o      (misr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (!BIST_Mode_Sel_i) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = patCount;
            state_d = (patCount != 12'd0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (!BIST_Mode_Sel_i) begin
            state_d = ST_IDLE;
          end else if (BIST_clk_en_i) begin
            cnt_d = cnt_q - 12'd1;
            if (cnt_q == 12'd1) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_IDLE, ST_DONE: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end
    // Status flags are registered from the next state so they align with it
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CUT_stim_o    = (state_q == ST_RUN) ? lfsr[CUT_W-1:0] : '0;
  assign To_BIST_reg_o = misr;
  assign BIST_busy_o   = busy_q;
  assign BIST_done_o   = done_q;

`ifdef BIST_GOLDEN_CMP_EN
  assign BIST_pass_o = done_q & (misr == GOLDEN_SIG);
  logic unusedCfg;
  assign unusedCfg = ^From_BIST_reg_i[15:12];
`else
  // Signature is judged off-chip through To_BIST_reg
  assign BIST_pass_o = 1'b0;
  logic unusedCfg;
  assign unusedCfg = ^{From_BIST_reg_i[15:12], GOLDEN_SIG};
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: randomized runs against a signature
// model built from the shift/feedback rules, plus abort and reset scenarios.
module tb_bist_sequencer;

  localparam int          CUT_W   = 16;
  localparam logic [15:0] TB_SEED = 16'hACE1;
  localparam logic [15:0] GOLDEN  = 16'h0000;
`ifdef BIST_GOLDEN_CMP_EN
  localparam logic PASS_ENABLED = 1'b1;
`else
  localparam logic PASS_ENABLED = 1'b0;
`endif

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          doneEdge;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             fsmRes, clkEn, modeSel;
  logic [15:0]      fromReg;
  logic [CUT_W-1:0] cutResp, cutStim;
  logic [15:0]      toReg;
  logic             busy, done, pass;
  int               respMode = 0;
  int               checks = 0;
  int               failures = 0;
  int               edgeCnt = 0;
  exp_t             sbQ[$];
  logic [15:0]      stimSeen[$];
  exp_t             monE;
  logic             prevDone = 1'b0;

  bist_sequencer #(
    .CUT_W(CUT_W), .SEED(TB_SEED), .GOLDEN_SIG(GOLDEN)
  ) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .BIST_FSM_RES_i (fsmRes),
    .BIST_clk_en_i  (clkEn),
    .BIST_Mode_Sel_i(modeSel),
    .From_BIST_reg_i(fromReg),
    .CUT_resp_i     (cutResp),
    .CUT_stim_o     (cutStim),
    .To_BIST_reg_o  (toReg),
    .BIST_busy_o    (busy),
    .BIST_done_o    (done),
    .BIST_pass_o    (pass)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  // Behavioural CUT: loopback, constant one, or a byte-swap scrambler
  function automatic logic [15:0] cutFunc(input logic [15:0] s, input int m);
    case (m)
      0:       return s;
      1:       return 16'h0001;
      default: return {s[7:0], s[15:8]} ^ 16'h5A3C;
    endcase
  endfunction

  function automatic logic [15:0] stepReg(input logic [15:0] x, input logic [15:0] din);
    logic fbBit;
    fbBit = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fbBit} ^ din;
  endfunction

  always_comb cutResp = cutFunc(cutStim, respMode);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: each rising BIST_done retires one scoreboard entry
  always @(negedge clock) begin
    if (done && !prevDone) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("done_signature", toReg, monE.sig);
        checkOutput("done_pass", pass, monE.pass);
        checkOutput("done_edge", edgeCnt, monE.doneEdge);
      end
    end
    prevDone = done;
  end

  // stopKind 0 drops BIST_Mode_Sel, 1 asserts reset, at RUN cycle stopAt
  task automatic applyStimulus(input int n, input int mode, input int enPct,
                               input int stopAt, input int stopKind);
    logic [15:0] lf, ms, expSig;
    logic        expPass;
    int          given, cyc;
    exp_t        e;
    respMode = mode;
    fromReg  = {4'($urandom_range(0, 15)), 12'(n)};
    lf = TB_SEED;
    ms = 16'h0000;
    for (int i = 0; i < n; i++) begin
      ms = stepReg(ms, cutFunc(lf, mode));
      lf = stepReg(lf, 16'h0000);
    end
    expSig  = ms;
    expPass = PASS_ENABLED && (expSig == GOLDEN);
    stimSeen.delete();
    @(negedge clock);
    fsmRes  = 1'b1;
    modeSel = 1'b1;
    clkEn   = 1'($urandom_range(0, 1));
    @(negedge clock);
    fsmRes = 1'b0;
    clkEn  = 1'($urandom_range(0, 1));
    checkOutput("load_busy", busy, 1);
    checkOutput("load_done", done, 0);
    checkOutput("load_stim", cutStim, 0);
    if (n == 0) begin
      e.sig = expSig; e.pass = expPass; e.doneEdge = edgeCnt + 1;
      sbQ.push_back(e);
    end
    lf = TB_SEED;
    ms = 16'h0000;
    given = 0;
    cyc = 0;
    @(negedge clock);
    while (given < n) begin
      checkOutput("run_stim", cutStim, lf);
      checkOutput("run_busy", busy, 1);
      stimSeen.push_back(cutStim);
      if (cyc == stopAt) begin
        if (stopKind == 0) begin
          modeSel = 1'b0;
          clkEn   = 1'b1;
          @(negedge clock);
          checkOutput("abort_busy", busy, 0);
          checkOutput("abort_done", done, 0);
          checkOutput("abort_stim", cutStim, 0);
          checkOutput("abort_sig_kept", toReg, ms);
          modeSel = 1'b1;
          clkEn   = 1'b0;
          @(negedge clock);
          checkOutput("abort_idle_busy", busy, 0);
        end else begin
          #2 reset = 1'b1;
          #1;
          checkOutput("rst_sig", toReg, 0);
          checkOutput("rst_stim", cutStim, 0);
          checkOutput("rst_busy", busy, 0);
          checkOutput("rst_done", done, 0);
          checkOutput("rst_pass", pass, 0);
          @(negedge clock);
          reset = 1'b0;
          @(negedge clock);
          checkOutput("rst_idle_busy", busy, 0);
          checkOutput("rst_idle_sig", toReg, 0);
        end
        return;
      end
      if (enPct < 0) clkEn = (cyc % 2 == 0);
      else           clkEn = ($urandom_range(0, 99) < enPct);
      if (clkEn) begin
        if (given == n - 1) begin
          e.sig = expSig; e.pass = expPass; e.doneEdge = edgeCnt + 1;
          sbQ.push_back(e);
        end
        ms = stepReg(ms, cutFunc(lf, mode));
        lf = stepReg(lf, 16'h0000);
        given++;
      end
      cyc++;
      @(negedge clock);
    end
    clkEn = 1'($urandom_range(0, 1));
    repeat (2) begin
      checkOutput("done_hold", done, 1);
      checkOutput("done_sig_hold", toReg, expSig);
      checkOutput("done_stim", cutStim, 0);
      @(negedge clock);
    end
  endtask

  initial begin
    reset   = 1'b1;
    fsmRes  = 1'b0;
    clkEn   = 1'b0;
    modeSel = 1'b0;
    fromReg = 16'h0000;
    repeat (2) @(negedge clock);
    checkOutput("reset_sig", toReg, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_stim", cutStim, 0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle_busy", busy, 0);

    applyStimulus(1, 0, 100, -1, 0);
    checkOutput("loop_n1_sig", toReg, 16'hACE1);
    applyStimulus(2, 0, 100, -1, 0);
    checkOutput("loop_n2_second_stim", stimSeen[1], 16'h59C3);
    applyStimulus(2, 1, 100, -1, 0);
    checkOutput("const_n2_sig", toReg, 16'h0003);
    applyStimulus(1, 1, 100, -1, 0);
    checkOutput("const_n1_sig", toReg, 16'h0001);
    applyStimulus(3, 2, -1, -1, 0);
    applyStimulus(0, 2, 100, -1, 0);
    checkOutput("n0_sig", toReg, 16'h0000);
    checkOutput("n0_pass", pass, PASS_ENABLED);
    applyStimulus(20, 2, 100, 5, 0);
    applyStimulus(4, 0, 100, -1, 0);
    applyStimulus(100, 0, 100, 10, 1);

    for (int r = 0; r < 10; r++) begin
      applyStimulus($urandom_range(0, 40), $urandom_range(0, 2), $urandom_range(40, 100), -1, 0);
    end

    repeat (3) @(negedge clock);
    checkOutput("pending_done", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
